pcf8591_scan: RTL and testbench

- Parametrised successor of the PCF8591 DAC/ADC sequencer.
- Drives the existing I2C byte-driver handshake: exec, rh_wl, addr, data_w, data_r, done.
- Generates the DAC output in one of three run-time selectable modes.
- Scans 1..4 ADC channels round-robin, discarding the stale first read after each channel switch.
- Averages 2^AVG_SHIFT samples per channel, scales the result to millivolts and publishes it per channel with a valid strobe. Sits between the I2C driver and the display/host logic.

---
 rtl/pcf8591_pkg.sv | 34 +++
 rtl/pcf8591_dac_gen.sv | 73 +++++++
 rtl/pcf8591_scan.sv | 211 +++++++++++++++++++++
 tb/tb_pcf8591_scan.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcf8591_pkg.sv
// Shared types and constants for the PCF8591 DAC/ADC scan sequencer.
package pcf8591_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_DA_REQ  = 3'd1,
        S_DA_WAIT = 3'd2,
        S_GAP     = 3'd3,
        S_AD_REQ  = 3'd4,
        S_AD_WAIT = 3'd5,
        S_UPDATE  = 3'd6
    } state_t;

    // Control byte base: analog output on, four single-ended inputs, no auto-increment
    localparam logic [7:0] CTRL_BASE = 8'h40;

    // DAC generator modes; code 3 behaves like fixed
    localparam logic [1:0] DAC_RAMP      = 2'd0;
    localparam logic [1:0] DAC_FIXED     = 2'd1;
    localparam logic [1:0] DAC_TRI       = 2'd2;
    localparam logic [1:0] DAC_FIXED_ALT = 2'd3;

    // Width of one per-channel millivolt result
    localparam int MV_W = 12;

    // Scale an 8-bit ADC average to millivolts: (vref * avg) >> 8
    function automatic logic [MV_W-1:0] mv_scale(input logic [11:0] vref, input logic [7:0] avg);
        logic [19:0] prod;
        prod = 20'(vref) * 20'(avg);
        return prod[19:8];
    endfunction

endpackage

// File: rtl/pcf8591_dac_gen.sv
// DAC code generator: ramp, triangle or fixed value, stepped once per completed write.
module pcf8591_dac_gen
    import pcf8591_pkg::*;
(
    input  logic       clk_pcf8591,
    input  logic       rst,
    input  logic       latch,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic [7:0] set,
    output logic [7:0] code
);

    logic [7:0] code_r;
    logic [1:0] mode_r;
    logic       down_r;
    logic       fixed_s;

    // Code offered for the next write; fixed mode takes the live set value
    always_comb begin
        fixed_s = (mode == DAC_FIXED) || (mode == DAC_FIXED_ALT);
        if (fixed_s) begin
            code = set;
        end else begin
            code = code_r;
        end
    end

    // Mode is latched at the write request; the code advances after the write completes
    always_ff @(posedge clk_pcf8591 or posedge rst) begin
        if (rst) begin
            code_r <= 8'd0;
            mode_r <= 2'd0;
            down_r <= 1'b0;
        end else if (latch) begin
            mode_r <= mode;
            if (fixed_s) begin
                code_r <= set;
            end else begin
                code_r <= code_r;
            end
        end else if (step) begin
            case (mode_r)
                DAC_RAMP: begin
                    code_r <= code_r + 8'd1;
                end
                DAC_TRI: begin
                    if (!down_r) begin
                        if (code_r == 8'd255) begin
                            code_r <= 8'd254;
                            down_r <= 1'b1;
                        end else begin
                            code_r <= code_r + 8'd1;
                        end
                    end else begin
                        if (code_r == 8'd0) begin
                            code_r <= 8'd1;
                            down_r <= 1'b0;
                        end else begin
                            code_r <= code_r - 8'd1;
                        end
                    end
                end
                default: begin
                    code_r <= code_r;
                end
            endcase
        end else begin
            code_r <= code_r;
        end
    end

endmodule

// File: rtl/pcf8591_scan.sv
// PCF8591 sequencer: DAC output generation plus round-robin averaged ADC scan in mV.
module pcf8591_scan
    import pcf8591_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int V_REF       = 3300,
    parameter int AVG_SHIFT   = 2,
    parameter int INIT_WAIT   = 100,
    parameter int SAMPLE_WAIT = 128906,
    parameter int TIMEOUT     = 200000
) (
    input  logic                   clk_pcf8591,
    input  logic                   rst,
    input  logic [1:0]             dac_mode,
    input  logic [7:0]             dac_set,
    output logic                   i2c_rh_wl_pcf8591,
    output logic                   i2c_exec_pcf8591,
    output logic [15:0]            i2c_addr_pcf8591,
    output logic [7:0]             i2c_data_w_pcf8591,
    input  logic [7:0]             i2c_data_r_pcf8591,
    input  logic                   i2c_done_pcf8591,
    output logic [7:0]             dac_code,
    output logic [NUM_CH*MV_W-1:0] ch_mv,
    output logic                   ch_valid,
    output logic [1:0]             ch_idx,
    output logic                   err_timeout
);

    localparam int ACC_W = 8 + AVG_SHIFT;
    localparam int SMP_W = AVG_SHIFT + 1;

    state_t                  state_r;
    logic [31:0]             wait_cnt_r;
    logic [1:0]              cur_ch_r;
    logic                    dummy_r;
    logic [ACC_W-1:0]        acc_r;
    logic [SMP_W-1:0]        smp_r;
    logic                    exec_r;
    logic                    rh_wl_r;
    logic [15:0]             addr_r;
    logic [7:0]              data_w_r;
    logic [7:0]              dac_code_r;
    logic [NUM_CH*MV_W-1:0]  ch_mv_r;
    logic                    ch_valid_r;
    logic [1:0]              ch_idx_r;
    logic                    err_timeout_r;

    logic                    gen_latch_s;
    logic                    gen_step_s;
    logic [7:0]              gen_code_s;
    logic [7:0]              avg_s;
    logic [MV_W-1:0]         mv_s;
    logic [15:0]             ctrl_s;
    logic                    last_smp_s;
    logic                    last_ch_s;
    logic                    wait_exp_s;

    pcf8591_dac_gen u_dac_gen (
        .clk_pcf8591 (clk_pcf8591),
        .rst         (rst),
        .latch       (gen_latch_s),
        .step        (gen_step_s),
        .mode        (dac_mode),
        .set         (dac_set),
        .code        (gen_code_s)
    );

    // Decode helpers: generator handshake, averaging/scaling and loop terminations
    always_comb begin
        gen_latch_s = (state_r == S_DA_REQ);
        gen_step_s  = (state_r == S_DA_WAIT) && i2c_done_pcf8591;
        avg_s       = 8'(acc_r >> AVG_SHIFT);
        mv_s        = mv_scale(12'(V_REF), avg_s);
        ctrl_s      = {8'h00, CTRL_BASE | {6'b000000, cur_ch_r}};
        last_smp_s  = (smp_r == SMP_W'((1 << AVG_SHIFT) - 1));
        last_ch_s   = (cur_ch_r == 2'(NUM_CH - 1));
        wait_exp_s  = (wait_cnt_r >= 32'(TIMEOUT));
    end

    // Main sequencer with registered I2C request and result outputs
    always_ff @(posedge clk_pcf8591 or posedge rst) begin
        if (rst) begin
            state_r       <= S_INIT;
            wait_cnt_r    <= 32'd0;
            cur_ch_r      <= 2'd0;
            dummy_r       <= 1'b0;
            acc_r         <= '0;
            smp_r         <= '0;
            exec_r        <= 1'b0;
            rh_wl_r       <= 1'b0;
            addr_r        <= 16'd0;
            data_w_r      <= 8'd0;
            dac_code_r    <= 8'd0;
            ch_mv_r       <= '0;
            ch_valid_r    <= 1'b0;
            ch_idx_r      <= 2'd0;
            err_timeout_r <= 1'b0;
        end else begin
            exec_r     <= 1'b0;
            ch_valid_r <= 1'b0;
            case (state_r)
                S_INIT: begin
                    if (wait_cnt_r + 32'd1 >= 32'(INIT_WAIT)) begin
                        wait_cnt_r <= 32'd0;
                        state_r    <= S_DA_REQ;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                S_DA_REQ: begin
                    exec_r     <= 1'b1;
                    rh_wl_r    <= 1'b0;
                    addr_r     <= ctrl_s;
                    data_w_r   <= gen_code_s;
                    wait_cnt_r <= 32'd0;
                    state_r    <= S_DA_WAIT;
                end
                S_DA_WAIT: begin
                    if (i2c_done_pcf8591) begin
                        dac_code_r <= data_w_r;
                        wait_cnt_r <= 32'd0;
                        state_r    <= S_GAP;
                    end else if (wait_exp_s) begin
                        err_timeout_r <= 1'b1;
                        acc_r         <= '0;
                        smp_r         <= '0;
                        dummy_r       <= 1'b1;
                        wait_cnt_r    <= 32'd0;
                        state_r       <= S_GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                S_GAP: begin
                    if (wait_cnt_r + 32'd1 >= 32'(SAMPLE_WAIT)) begin
                        wait_cnt_r <= 32'd0;
                        state_r    <= S_AD_REQ;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                S_AD_REQ: begin
                    exec_r     <= 1'b1;
                    rh_wl_r    <= 1'b1;
                    addr_r     <= ctrl_s;
                    wait_cnt_r <= 32'd0;
                    state_r    <= S_AD_WAIT;
                end
                S_AD_WAIT: begin
                    if (i2c_done_pcf8591) begin
                        wait_cnt_r <= 32'd0;
                        if (dummy_r) begin
                            // Stale conversion from the previous channel: drop it and re-read
                            dummy_r <= 1'b0;
                            state_r <= S_AD_REQ;
                        end else begin
                            acc_r <= acc_r + ACC_W'(i2c_data_r_pcf8591);
                            smp_r <= smp_r + SMP_W'(1);
                            if (last_smp_s) begin
                                state_r <= S_UPDATE;
                            end else begin
                                state_r <= S_DA_REQ;
                            end
                        end
                    end else if (wait_exp_s) begin
                        err_timeout_r <= 1'b1;
                        acc_r         <= '0;
                        smp_r         <= '0;
                        dummy_r       <= 1'b1;
                        wait_cnt_r    <= 32'd0;
                        state_r       <= S_GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                S_UPDATE: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (cur_ch_r == 2'(k)) begin
                            ch_mv_r[k*MV_W +: MV_W] <= mv_s;
                        end
                    end
                    ch_valid_r <= 1'b1;
                    ch_idx_r   <= cur_ch_r;
                    acc_r      <= '0;
                    smp_r      <= '0;
                    if (last_ch_s) begin
                        cur_ch_r <= 2'd0;
                    end else begin
                        cur_ch_r <= cur_ch_r + 2'd1;
                    end
                    dummy_r <= (NUM_CH > 1);
                    state_r <= S_DA_REQ;
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

    assign i2c_exec_pcf8591   = exec_r;
    assign i2c_rh_wl_pcf8591  = rh_wl_r;
    assign i2c_addr_pcf8591   = addr_r;
    assign i2c_data_w_pcf8591 = data_w_r;
    assign dac_code           = dac_code_r;
    assign ch_mv              = ch_mv_r;
    assign ch_valid           = ch_valid_r;
    assign ch_idx             = ch_idx_r;
    assign err_timeout        = err_timeout_r;

endmodule

// File: tb/tb_pcf8591_scan.sv
// Directed bench for pcf8591_scan: one single-channel and one four-channel instance.
module tb_pcf8591_scan;

    localparam int IW  = 10;
    localparam int SW  = 4;
    localparam int TO  = 40;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dac_mode = 2'd0;
    logic [7:0] dac_set  = 8'd0;
    logic       withhold1 = 1'b0;

    logic        ex1, rh1, done1, v1, err1;
    logic [15:0] addr1;
    logic [7:0]  dw1, dr1, dc1;
    logic [11:0] mv1;
    logic [1:0]  idx1;

    logic        ex4, rh4, done4, v4, err4;
    logic [15:0] addr4;
    logic [7:0]  dw4, dr4, dc4;
    logic [47:0] mv4;
    logic [1:0]  idx4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcf8591_scan #(.NUM_CH(1), .V_REF(3300), .AVG_SHIFT(0), .INIT_WAIT(IW),
                   .SAMPLE_WAIT(SW), .TIMEOUT(TO)) u_dut1 (
        .clk_pcf8591(clk), .rst(rst), .dac_mode(dac_mode), .dac_set(dac_set),
        .i2c_rh_wl_pcf8591(rh1), .i2c_exec_pcf8591(ex1), .i2c_addr_pcf8591(addr1),
        .i2c_data_w_pcf8591(dw1), .i2c_data_r_pcf8591(dr1), .i2c_done_pcf8591(done1),
        .dac_code(dc1), .ch_mv(mv1), .ch_valid(v1), .ch_idx(idx1), .err_timeout(err1)
    );

    pcf8591_scan #(.NUM_CH(4), .V_REF(3300), .AVG_SHIFT(2), .INIT_WAIT(IW),
                   .SAMPLE_WAIT(SW), .TIMEOUT(TO)) u_dut4 (
        .clk_pcf8591(clk), .rst(rst), .dac_mode(dac_mode), .dac_set(dac_set),
        .i2c_rh_wl_pcf8591(rh4), .i2c_exec_pcf8591(ex4), .i2c_addr_pcf8591(addr4),
        .i2c_data_w_pcf8591(dw4), .i2c_data_r_pcf8591(dr4), .i2c_done_pcf8591(done4),
        .dac_code(dc4), .ch_mv(mv4), .ch_valid(v4), .ch_idx(idx4), .err_timeout(err4)
    );

    // I2C driver model for the single-channel instance: always returns 128, done can be withheld
    logic     busy1, rd1m;
    int       lat1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy1 <= 1'b0; lat1 <= 0; done1 <= 1'b0; dr1 <= 8'd0; rd1m <= 1'b0;
        end else begin
            done1 <= 1'b0;
            if (busy1) begin
                if (lat1 == 0) begin
                    busy1 <= 1'b0;
                    if (!withhold1) begin
                        done1 <= 1'b1;
                        dr1   <= 8'd128;
                    end
                end else begin
                    lat1 <= lat1 - 1;
                end
            end else if (ex1) begin
                busy1 <= 1'b1; lat1 <= LAT; rd1m <= rh1;
            end
        end
    end

    // I2C driver model for the four-channel instance: 0xFF on a stale read, 0x10*(ch+1) otherwise
    logic     busy4;
    int       lat4, dcnt4;
    logic [1:0] prev4;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy4 <= 1'b0; lat4 <= 0; done4 <= 1'b0; dr4 <= 8'd0; prev4 <= 2'd0; dcnt4 <= 0;
        end else begin
            done4 <= 1'b0;
            if (busy4) begin
                if (lat4 == 0) begin
                    busy4 <= 1'b0;
                    done4 <= 1'b1;
                end else begin
                    lat4 <= lat4 - 1;
                end
            end else if (ex4) begin
                busy4 <= 1'b1; lat4 <= LAT;
                if (rh4) begin
                    prev4 <= addr4[1:0];
                    if (addr4[1:0] != prev4) begin
                        dr4   <= 8'hFF;
                        dcnt4 <= dcnt4 + 1;
                    end else begin
                        dr4 <= 8'(16 * (int'(addr4[1:0]) + 1));
                    end
                end
            end
        end
    end

    // Record the first eight result strobes of the four-channel instance
    int          rec_n = 0;
    logic [1:0]  rec_idx [8];
    logic [11:0] rec_mv  [8];
    int          rec_dum [8];
    always @(negedge clk) begin
        if (v4 && rec_n < 8) begin
            rec_idx[rec_n] <= idx4;
            rec_mv[rec_n]  <= mv4[idx4*12 +: 12];
            rec_dum[rec_n] <= dcnt4;
            rec_n          <= rec_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0 any exec, 1 write exec, 2 read exec
    task automatic wait_exec1(input int kind, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(posedge clk); #1; n++;
            if (ex1 && (kind == 0 || (kind == 1 && !rh1) || (kind == 2 && rh1))) ok = 1'b1;
        end
    endtask

    // which: 0 done1, 1 ch_valid of dut1, 2 err_timeout of dut1
    task automatic wait_flag1(input int which, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(posedge clk); #1; n++;
            if ((which == 0 && done1) || (which == 1 && v1) || (which == 2 && err1)) ok = 1'b1;
        end
    endtask

    task automatic release_and_check_start(input string tag);
        int n; bit ok;
        @(negedge clk); rst = 1'b0;
        wait_exec1(0, 200, n, ok);
        check_val({tag, "_exec_seen"}, 32'(ok), 32'd1);
        check_val({tag, "_exec_delay"}, 32'(n), 32'(IW + 1));
        check_val({tag, "_addr"}, 32'(addr1), 32'h0040);
        check_val({tag, "_data_w"}, 32'(dw1), 32'd0);
        check_val({tag, "_rh_wl"}, 32'(rh1), 32'd0);
    endtask

    initial begin
        int n, m, rd, bad, e;
        bit ok, up;
        logic [11:0] exp_mv [4];
        exp_mv[0] = 12'd206; exp_mv[1] = 12'd412; exp_mv[2] = 12'd618; exp_mv[3] = 12'd825;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_exec", 32'(ex1), 32'd0);
        check_val("rst_addr", 32'(addr1), 32'd0);
        check_val("rst_dac_code", 32'(dc1), 32'd0);
        check_val("rst_mv1", 32'(mv1), 32'd0);
        check_val("rst_mv4_lo", mv4[31:0], 32'd0);
        check_val("rst_mv4_hi", 32'(mv4[47:32]), 32'd0);
        check_val("rst_valid", 32'(v1 | v4), 32'd0);
        check_val("rst_err", 32'(err1 | err4), 32'd0);

        // Single channel, no averaging, ramp
        release_and_check_start("s1");
        rd = 0; ok = 1'b0; n = 0;
        if (rh1) rd++;
        while (!ok && n < 500) begin
            @(posedge clk); #1; n++;
            if (ex1 && rh1) rd++;
            if (v1) ok = 1'b1;
        end
        check_val("s1_valid_seen", 32'(ok), 32'd1);
        check_val("s1_mv", 32'(mv1), 32'd1650);
        check_val("s1_idx", 32'(idx1), 32'd0);
        check_val("s1_reads", 32'(rd), 32'd1);
        check_val("s1_dac_code", 32'(dc1), 32'd0);

        // Four channels averaged over four samples
        n = 0;
        while (rec_n < 5 && n < 3000) begin
            @(posedge clk); n++;
        end
        @(negedge clk);
        check_val("s2_count", 32'(rec_n >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_val("s2_idx", 32'(rec_idx[i]), 32'(i % 4));
            check_val("s2_mv", 32'(rec_mv[i]), 32'(exp_mv[i % 4]));
            check_val("s2_dummies", 32'(rec_dum[i]), 32'(i));
        end

        // Reset while a read completes in the same cycle
        ok = 1'b0; n = 0;
        while (!ok && n < 300) begin
            @(posedge clk); #1; n++;
            if (done1 && rd1m) ok = 1'b1;
        end
        check_val("s6_read_done_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check_val("s6_exec", 32'(ex1), 32'd0);
        check_val("s6_addr", 32'(addr1), 32'd0);
        check_val("s6_data_w", 32'(dw1), 32'd0);
        check_val("s6_mv", 32'(mv1), 32'd0);
        check_val("s6_dac_code", 32'(dc1 | dc4), 32'd0);
        check_val("s6_mv4", mv4[31:0] | 32'(mv4[47:32]), 32'd0);
        bad = 0;
        if (v1) bad++;
        repeat (4) begin
            @(posedge clk); #1;
            if (v1) bad++;
        end
        check_val("s6_no_valid", 32'(bad), 32'd0);
        release_and_check_start("s6");

        // Triangle over 600 writes from a fresh reset
        @(negedge clk); rst = 1'b1; dac_mode = 2'd2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e = 0; up = 1'b1;
        for (int i = 0; i < 600; i++) begin
            wait_exec1(1, 200, n, ok);
            check_val("tri_data_w", ok ? 32'(dw1) : 32'hFFFF_FFFF, 32'(e));
            if (up) begin
                if (e == 255) begin e = 254; up = 1'b0; end else e++;
            end else begin
                if (e == 0) begin e = 1; up = 1'b1; end else e--;
            end
        end

        // Fixed mode, then a new fixed value
        dac_mode = 2'd1; dac_set = 8'hA5;
        wait_exec1(1, 200, n, ok);
        check_val("fix_a5_data_w", ok ? 32'(dw1) : 32'hFFFF_FFFF, 32'h00A5);
        wait_flag1(0, 200, n, ok);
        @(posedge clk); #1;
        check_val("fix_a5_dac_code", 32'(dc1), 32'h00A5);
        dac_set = 8'h3C;
        wait_exec1(1, 200, n, ok);
        check_val("fix_3c_data_w", ok ? 32'(dw1) : 32'hFFFF_FFFF, 32'h003C);
        check_val("fix_code_before_done", 32'(dc1), 32'h00A5);
        wait_flag1(0, 200, n, ok);
        @(posedge clk); #1;
        check_val("fix_3c_dac_code", 32'(dc1), 32'h003C);

        // Withheld completion: timeout, recovery, sticky flag
        wait_flag1(0, 200, n, ok);
        withhold1 = 1'b1;
        wait_exec1(0, 200, n, ok);
        check_val("to_exec_seen", 32'(ok), 32'd1);
        wait_flag1(2, 200, m, ok);
        check_val("to_err_seen", 32'(ok), 32'd1);
        check_val("to_delay", 32'(m), 32'(TO + 1));
        withhold1 = 1'b0;
        wait_exec1(0, 200, n, ok);
        check_val("to_resume_delay", 32'(n), 32'(SW + 1));
        check_val("to_resume_read", 32'(rh1), 32'd1);
        wait_flag1(1, 500, n, ok);
        check_val("to_resume_valid", 32'(ok), 32'd1);
        check_val("to_resume_mv", 32'(mv1), 32'd1650);
        check_val("to_sticky", 32'(err1), 32'd1);
        @(negedge clk); rst = 1'b1;
        #1;
        check_val("to_cleared_by_rst", 32'(err1), 32'd0);
        @(negedge clk); rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
